// File: rtl/nf_ahb_pwm_mc_if.sv
// AHB-Lite slave port bundle for nf_ahb_pwm_mc.
// The master modport is the bus (interconnect or testbench) side and the slave modport is the PWM side.
interface nf_ahb_pwm_mc_if;
    logic [31:0] haddr_s;
    logic [31:0] hwdata_s;
    logic [31:0] hrdata_s;
    logic        hwrite_s;
    logic [1:0]  htrans_s;
    logic [2:0]  hsize_s;
    logic [2:0]  hburst_s;
    logic [1:0]  hresp_s;
    logic        hready_s;
    logic        hsel_s;

    modport master (
        output haddr_s, hwdata_s, hwrite_s, htrans_s, hsize_s, hburst_s, hsel_s,
        input  hrdata_s, hresp_s, hready_s
    );

    modport slave (
        input  haddr_s, hwdata_s, hwrite_s, htrans_s, hsize_s, hburst_s, hsel_s,
        output hrdata_s, hresp_s, hready_s
    );
endinterface

// File: rtl/nf_ahb_pwm_mc.sv
// Multi-channel AHB-Lite PWM slave.
// Zero-wait-state register block. One prescaled period counter is shared by all channels.
// Each channel has a double-buffered duty register that takes effect at period wrap.
// A sticky wrap flag drives a level interrupt.
module nf_ahb_pwm_mc #(
    parameter int ch_n  = 4,
    parameter int pwm_w = 8
) (
    input  logic             hclk,
    input  logic             hreset,
    nf_ahb_pwm_mc_if.slave   ahb,
    output logic [ch_n-1:0]  pwm,
    output logic             irq
);

    localparam logic [5:0] ADDR_CTRL   = 6'd0;
    localparam logic [5:0] ADDR_PERIOD = 6'd1;
    localparam logic [5:0] ADDR_STATUS = 6'd2;
    localparam logic [5:0] ADDR_CHEN   = 6'd3;
    localparam logic [5:0] ADDR_DUTY0  = 6'd4;

    // Captured address phase
    logic             addr_valid_q;
    logic             write_q;
    logic [5:0]       addr_q;

    // Programmer-visible registers
    logic             en_q;
    logic             ie_q;
    logic [15:0]      psc_q;
    logic [pwm_w-1:0] period_q;
    logic             status_q;
    logic [ch_n-1:0]  chen_q;
    logic [pwm_w-1:0] duty_q [ch_n];

    // PWM engine
    logic [15:0]      pre_cnt_q;
    logic [15:0]      pre_cnt_d;
    logic [pwm_w-1:0] cnt_q;
    logic [pwm_w-1:0] cnt_d;
    logic [pwm_w-1:0] per_act_q;
    logic [pwm_w-1:0] duty_act_q [ch_n];
    logic [ch_n-1:0]  pwm_q;
    logic             tick_s;
    logic             wrap_s;

    logic             wr_s;
    logic             rd_s;
    logic             addr_ok_s;
    logic [31:0]      rdata_s;
    logic             unused_s;

    assign addr_ok_s = ahb.hsel_s & ahb.htrans_s[1];
    assign wr_s      = addr_valid_q & write_q;
    assign rd_s      = addr_valid_q & ~write_q;

    // Width, burst, the upper address bits and the unused data bits carry no meaning for this slave.
    assign unused_s = ^{ahb.haddr_s, ahb.hwdata_s, ahb.htrans_s, ahb.hsize_s, ahb.hburst_s};

    // Capture a valid address phase for use in the following data phase.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            addr_valid_q <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= 6'd0;
        end else begin
            addr_valid_q <= addr_ok_s;
            if (addr_ok_s) begin
                addr_q  <= ahb.haddr_s[7:2];
                write_q <= ahb.hwrite_s;
            end
        end
    end

    // Data-phase writes into the control, period, channel-enable and duty shadow registers.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            en_q     <= 1'b0;
            ie_q     <= 1'b0;
            psc_q    <= 16'd0;
            period_q <= {pwm_w{1'b0}};
            chen_q   <= {ch_n{1'b0}};
            for (int i = 0; i < ch_n; i++) begin
                duty_q[i] <= {pwm_w{1'b0}};
            end
        end else if (wr_s) begin
            case (addr_q)
                ADDR_CTRL: begin
                    en_q  <= ahb.hwdata_s[0];
                    ie_q  <= ahb.hwdata_s[1];
                    psc_q <= ahb.hwdata_s[31:16];
                end
                ADDR_PERIOD: period_q <= ahb.hwdata_s[pwm_w-1:0];
                ADDR_CHEN:   chen_q   <= ahb.hwdata_s[ch_n-1:0];
                default: begin
                    for (int i = 0; i < ch_n; i++) begin
                        if (addr_q == ADDR_DUTY0 + 6'(i)) begin
                            duty_q[i] <= ahb.hwdata_s[pwm_w-1:0];
                        end
                    end
                end
            endcase
        end
    end

    // Sticky wrap flag; a wrap in the same cycle as a write-1-to-clear keeps it set.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            status_q <= 1'b0;
        end else if (wrap_s) begin
            status_q <= 1'b1;
        end else if (wr_s && (addr_q == ADDR_STATUS) && ahb.hwdata_s[0]) begin
            status_q <= 1'b0;
        end
    end

    // Prescaler and period counter next state, with tick and wrap strobes.
    always_comb begin
        tick_s    = 1'b0;
        wrap_s    = 1'b0;
        pre_cnt_d = pre_cnt_q;
        cnt_d     = cnt_q;
        if (!en_q) begin
            pre_cnt_d = 16'd0;
            cnt_d     = {pwm_w{1'b0}};
        end else if (pre_cnt_q == psc_q) begin
            tick_s    = 1'b1;
            pre_cnt_d = 16'd0;
            if (cnt_q == per_act_q) begin
                wrap_s = 1'b1;
                cnt_d  = {pwm_w{1'b0}};
            end else begin
                cnt_d  = cnt_q + pwm_w'(1'b1);
            end
        end else if (pre_cnt_q > psc_q) begin
            // PSC was lowered below the running count; restart instead of wrapping through 16 bits.
            pre_cnt_d = 16'd0;
        end else begin
            pre_cnt_d = pre_cnt_q + 16'd1;
        end
    end

    // Counters, plus the active period/duty copies: these track the shadows while disabled and reload on wrap.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            pre_cnt_q <= 16'd0;
            cnt_q     <= {pwm_w{1'b0}};
            per_act_q <= {pwm_w{1'b0}};
            for (int i = 0; i < ch_n; i++) begin
                duty_act_q[i] <= {pwm_w{1'b0}};
            end
        end else begin
            pre_cnt_q <= pre_cnt_d;
            cnt_q     <= cnt_d;
            if (!en_q || wrap_s) begin
                per_act_q <= period_q;
                for (int i = 0; i < ch_n; i++) begin
                    duty_act_q[i] <= duty_q[i];
                end
            end
        end
    end

    // Registered per-channel compare; duty above the period therefore stays high throughout.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            pwm_q <= {ch_n{1'b0}};
        end else begin
            for (int i = 0; i < ch_n; i++) begin
                pwm_q[i] <= en_q & chen_q[i] & (cnt_q < duty_act_q[i]);
            end
        end
    end

    // Read data mux for the captured address; zero outside a valid read data phase.
    always_comb begin
        rdata_s = 32'd0;
        if (rd_s) begin
            case (addr_q)
                ADDR_CTRL:   rdata_s = {psc_q, 14'd0, ie_q, en_q};
                ADDR_PERIOD: rdata_s = {{(32-pwm_w){1'b0}}, period_q};
                ADDR_STATUS: rdata_s = {31'd0, status_q};
                ADDR_CHEN:   rdata_s = {{(32-ch_n){1'b0}}, chen_q};
                default: begin
                    for (int i = 0; i < ch_n; i++) begin
                        rdata_s = (addr_q == ADDR_DUTY0 + 6'(i)) ?
                                  {{(32-pwm_w){1'b0}}, duty_q[i]} : rdata_s;
                    end
                end
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign ahb.hrdata_s = rdata_s;
    assign ahb.hready_s = 1'b1;
    assign ahb.hresp_s  = 2'b00;
    assign pwm          = pwm_q;
    assign irq          = ie_q & status_q;

endmodule

// File: doc/nf_ahb_pwm_mc.md
# nf_ahb_pwm_mc

Multi-channel AHB-Lite PWM slave, the parametrised successor of the single-channel AHB PWM. It sits on one slave port of the AHB interconnect, next to the GPIO slaves. It drives `ch_n` PWM outputs from one shared period counter with a programmable prescaler. Per-channel duty registers are double-buffered and take effect only at a period boundary, and a period-wrap interrupt is provided.

## Interface
- `ch_n`, 4: number of PWM channels, 1..16
- `pwm_w`, 8: counter, period and duty width, 1..16

- `hclk` in 1: clock; the PWM logic also runs on it
- `hreset` in 1: reset; one clock, synchronous, active-high
- `haddr_s` in 32: AHB HADDR; only bits [7:0] are decoded
- `hwdata_s` in 32: AHB HWDATA
- `hrdata_s` out 32: AHB HRDATA
- `hwrite_s` in 1: AHB HWRITE
- `htrans_s` in 2: AHB HTRANS
- `hsize_s` in 3: AHB HSIZE; ignored, all accesses are treated as 32-bit
- `hburst_s` in 3: AHB HBURST; ignored
- `hresp_s` out 2: AHB HRESP; constant 2'b00 (OKAY)
- `hready_s` out 1: AHB HREADYOUT; constant 1 (zero wait state)
- `hsel_s` in 1: AHB HSEL
- `pwm` out ch_n: PWM outputs
- `irq` out 1: period-wrap interrupt, level

## Operation
- **Transfer acceptance:** an address phase is valid when `hsel_s & htrans_s[1]`. In that case `haddr_s[7:2]` and `hwrite_s` are registered; otherwise the registered valid bit is cleared.
- **Data phase, write:** the register at the captured address takes `hwdata_s`. The new value is visible from the next cycle.
- **Data phase, read:** `hrdata_s` is driven combinationally from the captured address. When no valid read is in its data phase, `hrdata_s` is 0.
- **Register map** (unlisted bits read 0; unmapped addresses read 0 and ignore writes):
  - 0x00 CTRL: [0] EN, [1] IE, [31:16] PSC
  - 0x04 PERIOD: [pwm_w-1:0], shadow register
  - 0x08 STATUS: [0] WRAP, sticky, write-1-to-clear
  - 0x0C CHEN: [ch_n-1:0] per-channel enable
  - 0x10+4*i DUTY[i]: [pwm_w-1:0], shadow register, i < ch_n
- **Prescaler:** `pre_cnt` counts 0..PSC. `tick = EN & (pre_cnt == PSC)`. On tick `pre_cnt` returns to 0. PSC=0 gives a tick every cycle.
- **Period counter:** on tick, if `cnt == per_act` then `cnt <= 0` and `wrap` pulses; otherwise `cnt <= cnt + 1`. The period is `per_act + 1` ticks. `cnt` is pwm_w bits and never exceeds `per_act`.
- **Shadow load:** on wrap, `per_act <= PERIOD` and `duty_act[i] <= DUTY[i]`, using the register values as they stood at the start of that cycle. A bus write landing in the wrap cycle therefore applies at the following wrap.
- **EN=0:**
  - `pre_cnt` and `cnt` are held at 0 and no wraps occur.
  - `per_act` and `duty_act` copy the shadows every cycle, so enabling starts immediately with the programmed values.
- **Output:** `pwm[i] <= EN & CHEN[i] & (cnt < duty_act[i])`, registered.
  - Duty 0 gives a constant low output.
  - Duty > `per_act` gives a constant high output.
- **STATUS[0]:** set on wrap, cleared by writing 1. If both happen in the same cycle, set wins.
- **Interrupt:** `irq = IE & STATUS[0]`.
- **Reset:** all registers, `pre_cnt`, `cnt`, `per_act`, `duty_act`, the captured address/valid bit and `pwm` go to 0. `irq` and `hrdata_s` are therefore 0. `hready_s` stays 1 and `hresp_s` stays 2'b00 throughout. Reset in the middle of a transfer aborts that transfer; no register write occurs.

## Timing
- **Bus access:** zero wait state. Address phase in cycle N, data phase (write or read) in cycle N+1. A written value is visible to the PWM logic in N+2.
- **Back-to-back transfers:** accepted every cycle. A read immediately after a write to the same address returns the new value.
- **Output latency:** `pwm` lags `cnt` by one cycle. Set EN in data-phase cycle N: first tick in N+1 (PSC=0), first `pwm` high in N+2.
- **Wrap and interrupt:** `wrap` is a one-cycle internal pulse. STATUS and `irq` rise the cycle after it.
- **Output toggle points:** `pwm[i]` high for `duty_act[i]` ticks out of `per_act + 1`, each tick being PSC+1 clocks.

## Test plan
- **Basic period and duty:** PSC=0, PERIOD=9, DUTY0=3, CHEN=1, EN=1 -> `pwm[0]` high 3 of every 10 cycles; `pwm[3:1]` stay 0.
- **Prescaler:** PSC=1 with the previous settings -> `pwm[0]` high 6 of every 20 cycles.
- **Shadow update mid-period:** write DUTY0=7 at `cnt`=2 -> current period keeps 3 high; every following period has 7 high. Read-back of DUTY0 returns 7 immediately.
- **Boundary duties:** DUTY1=0 and DUTY2=0xFF with PERIOD=9 -> `pwm[1]` constant 0, `pwm[2]` constant 1. Clearing CHEN[2] forces `pwm[2]` to 0 the next cycle.
- **Interrupt and W1C:**
  - IE=1 -> `irq` rises one cycle after the wrap.
  - Write STATUS=1 -> `irq` falls.
  - W1C issued in the wrap cycle -> STATUS stays 1.
  - Write STATUS=0 -> no effect.
- **Reset and unmapped access:** assert `hreset` mid-period -> all outputs and registers read 0 and `pwm`=0 the next cycle. A read of 0xFC returns 0 with HRESP OKAY.
